// File: rtl/de_muldiv_pkg.sv
// rtl/de_muldiv_pkg.sv - shared types and helpers for the DE-stage multiply/divide unit
package de_muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int MAX_XLEN     = 64;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // request as presented by the DE stage (sized for the widest XLEN)
  typedef struct packed {
    logic                valid;
    muldiv_op_e          op;
    logic [MAX_XLEN-1:0] rs1;
    logic [MAX_XLEN-1:0] rs2;
  } muldiv_req_t;

  // rs1 is treated as signed
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // result comes from the high half (product high or remainder)
  function automatic logic op_sel_hi(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
           (op == OP_REM)  || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/de_muldiv_step.sv
// rtl/de_muldiv_step.sv - one combinational shift-add / restoring shift-subtract iteration
module muldiv_step
  import de_muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  // multiply: {hi,lo} holds partial product over remaining multiplier bits
  logic [XLEN:0] w_sum;
  // divide: {hi,lo} holds partial remainder and dividend/quotient bits
  logic [XLEN:0] w_shift;
  // remainder < divisor always, so the trial difference fits in XLEN+1 signed bits
  logic [XLEN:0] w_diff;
  logic          w_ge;

  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opb} : '0);
  assign w_shift = {i_hi, i_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_opb};
  assign w_ge    = ~w_diff[XLEN];

  // pick the multiply or divide iteration
  always_comb begin
    if (i_is_div) begin
      o_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/de_muldiv.sv
// rtl/de_muldiv.sv - iterative M-extension multiply/divide unit stalling the DE stage
module de_muldiv
  import de_muldiv_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            pipe_adv,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / BITS_PER_CYC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   r_state;
  muldiv_state_e   w_next;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  muldiv_op_e      r_op;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_stall;
  logic            w_res_valid;

  // request decode
  muldiv_op_e      w_op;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;

  assign w_op       = muldiv_op_e'(op);
  assign w_a_neg    = op_a_signed(w_op) & rs1[XLEN-1];
  assign w_b_neg    = op_b_signed(w_op) & rs2[XLEN-1];
  assign w_mag_a    = w_a_neg ? -rs1 : rs1;
  assign w_mag_b    = w_b_neg ? -rs2 : rs2;
  assign w_div_zero = w_op[2] & (rs2 == '0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (rs1 == MOST_NEG) && (rs2 == '1);
  assign w_special  = w_div_zero | w_ovf;

  // iteration chain, BITS_PER_CYC steps per cycle
  logic [BITS_PER_CYC:0][XLEN-1:0] w_hi;
  logic [BITS_PER_CYC:0][XLEN-1:0] w_lo;

  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  for (genvar gi = 0; gi < BITS_PER_CYC; gi++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (r_op[2]),
      .i_hi     (w_hi[gi]),
      .i_lo     (w_lo[gi]),
      .i_opb    (r_opb),
      .o_hi     (w_hi[gi+1]),
      .o_lo     (w_lo[gi+1])
    );
  end

  // sign correction applied on the last CALC cycle
  logic            w_last;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_fin_hi;
  logic [XLEN-1:0] w_fin_lo;
  logic [XLEN-1:0] w_upd_hi;
  logic [XLEN-1:0] w_upd_lo;

  assign w_last     = (r_count == CW'(1));
  assign w_prod     = {w_hi[BITS_PER_CYC], w_lo[BITS_PER_CYC]};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -w_lo[BITS_PER_CYC] : w_lo[BITS_PER_CYC];
  assign w_rem_fix  = r_neg_r ? -w_hi[BITS_PER_CYC] : w_hi[BITS_PER_CYC];
  assign w_fin_hi   = r_op[2] ? w_rem_fix : w_prod_fix[2*XLEN-1:XLEN];
  assign w_fin_lo   = r_op[2] ? w_quo_fix : w_prod_fix[XLEN-1:0];
  assign w_upd_hi   = w_last ? w_fin_hi : w_hi[BITS_PER_CYC];
  assign w_upd_lo   = w_last ? w_fin_lo : w_lo[BITS_PER_CYC];

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // next state and handshake outputs; flush overrides everything
  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_res_valid = 1'b0;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            w_stall = 1'b1;
            w_next  = w_special ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          w_stall = 1'b1;
          if (w_last) w_next = ST_DONE;
        end
        ST_DONE: begin
          w_res_valid = 1'b1;
          if (pipe_adv) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // operand latch, iteration and special-case results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_op    <= OP_MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= w_op;
            r_opb   <= w_mag_b;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div_zero) begin
              r_hi    <= rs1;
              r_lo    <= '1;
              r_count <= '0;
            end else if (w_ovf) begin
              r_hi    <= '0;
              r_lo    <= rs1;
              r_count <= '0;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_mag_a;
              r_count <= CW'(STEPS);
            end
          end
        end
        ST_CALC: begin
          r_hi    <= w_upd_hi;
          r_lo    <= w_upd_lo;
          r_count <= r_count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // outputs forced low while reset is asserted
  assign stall     = rst & w_stall;
  assign res_valid = rst & w_res_valid;
  assign result    = res_valid ? (op_sel_hi(r_op) ? r_hi : r_lo) : '0;

endmodule

// File: tb/tb_de_muldiv.sv
// tb/tb_de_muldiv.sv - directed-vector bench for de_muldiv
module tb_de_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        pipe_adv;
  logic        stall_a, stall_b;
  logic        vld_a, vld_b;
  logic [31:0] res_a, res_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  de_muldiv #(.XLEN(32), .BITS_PER_CYC(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_a), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .pipe_adv(pipe_adv), .stall(stall_a), .res_valid(vld_a), .result(res_a)
  );

  de_muldiv #(.XLEN(32), .BITS_PER_CYC(4)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_b), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .pipe_adv(pipe_adv), .stall(stall_b), .res_valid(vld_b), .result(res_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one op on DUT a (sel=0) or b (sel=1), check stall length, result and release
  task automatic do_op(input bit sel, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                       input int hold, input string tag);
    int n;
    @(negedge clk);
    op = f; rs1 = a; rs2 = b; pipe_adv = 1'b0;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    #1;
    n = 0;
    while ((sel ? stall_b : stall_a) && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_vld"}, {31'b0, sel ? vld_b : vld_a}, 32'd1);
    chk({tag, "_res"}, sel ? res_b : res_a, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_hold_vld"}, {31'b0, sel ? vld_b : vld_a}, 32'd1);
      chk({tag, "_hold_res"}, sel ? res_b : res_a, exp_r);
      chk({tag, "_hold_stall"}, {31'b0, sel ? stall_b : stall_a}, 32'd0);
    end
    pipe_adv = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; pipe_adv = 1'b0;
    #1;
    chk({tag, "_post_vld"}, {31'b0, sel ? vld_b : vld_a}, 32'd0);
    chk({tag, "_post_res"}, sel ? res_b : res_a, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; op = 3'd4;
    rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; flush = 1'b0; pipe_adv = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stall_a}, 32'd0);
    chk("rst_vld", {31'b0, vld_a}, 32'd0);
    chk("rst_res", res_a, 32'd0);
    chk("rst_stall_b", {31'b0, stall_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;

    for (int s = 0; s < 2; s++) begin
      int lat;
      lat = (s == 0) ? 33 : 9;
      do_op(s[0], 3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, lat, 0, "div_m7_2");
      do_op(s[0], 3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, lat, 0, "rem_m7_2");
      do_op(s[0], 3'd5, 32'd5,         32'd0,          32'hFFFF_FFFF, 1,   0, "divu_by0");
      do_op(s[0], 3'd7, 32'd5,         32'd0,          32'd5,         1,   0, "remu_by0");
      do_op(s[0], 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,   0, "div_ovf");
      do_op(s[0], 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,   0, "rem_ovf");
      do_op(s[0], 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat, 0, "mulh_min");
      do_op(s[0], 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, 0, "mulhsu_m1");
      do_op(s[0], 3'd0, 32'd7,         32'd6,          32'd42,        lat, 0, "mul_7_6");
      do_op(s[0], 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, 0, "mulhu_max");
      do_op(s[0], 3'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, lat, 0, "mul_m3_5");
      do_op(s[0], 3'd5, 32'd100,       32'd7,          32'd14,        lat, 0, "divu_100_7");
      do_op(s[0], 3'd7, 32'd100,       32'd7,          32'd2,         lat, 0, "remu_100_7");
      do_op(s[0], 3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, 0, "div_7_m2");
      do_op(s[0], 3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         lat, 0, "rem_7_m2");
    end

    // result held while pipe_adv stays low in DONE
    do_op(1'b0, 3'd0, 32'd7, 32'd6, 32'd42, 33, 3, "mul_hold");

    // flush during CALC cycle 10, with a new request presented in the same cycle
    @(negedge clk);
    op = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; req_a = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_pre_stall", {31'b0, stall_a}, 32'd1);
    flush = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    #1;
    chk("flush_stall", {31'b0, stall_a}, 32'd0);
    chk("flush_vld", {31'b0, vld_a}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req_a = 1'b0;
    #1;
    chk("flush_idle_stall", {31'b0, stall_a}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (vld_a) cnt++;
    end
    chk("flush_no_vld", 32'(cnt), 32'd0);

    // flush wins over a request in IDLE
    @(negedge clk);
    req_a = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_req_stall", {31'b0, stall_a}, 32'd0);
    @(negedge clk);
    req_a = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_ignored", {31'b0, stall_a}, 32'd0);

    // reset pulsed mid-CALC
    @(negedge clk);
    op = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; req_a = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid_pre_stall", {31'b0, stall_a}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_stall", {31'b0, stall_a}, 32'd0);
    chk("rstmid_vld", {31'b0, vld_a}, 32'd0);
    chk("rstmid_res", res_a, 32'd0);
    @(negedge clk);
    rst = 1'b1; req_a = 1'b0;
    do_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
